// File: rtl/eu_cache_rd_arbiter_pkg.sv
// Shared types for the execution-unit cache read arbiter: address/data types,
// the arbiter state enum, default sizing and a small index-wrap helper.
package pkg_dtypes;

  typedef logic [15:0] type_exec_unit_addr;
  typedef logic [31:0] type_exec_unit_data;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BACKOFF
  } type_eu_rdarb_state;

  localparam int EU_RDARB_NUM_REQ_DEFAULT   = 4;
  localparam int EU_RDARB_MAX_RETRY_DEFAULT = 7;

  // Explicit wrap keeps non-power-of-2 requester counts from producing idx >= n.
  function automatic int eu_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/eu_rr_pick.sv
// Combinational rotate-priority picker: first set, unmasked request at or
// above ptr, wrapping modulo N. Shared by the interconnect arbiters.
module eu_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  eligible;
  logic [IW-1:0] cand;
  int            pos;

  assign eligible = req & ~mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/eu_cache_rd_arbiter.sv
// Round-robin arbiter sharing one operand-cache read port between NUM_REQ
// requesters, with linear-backoff retry. Optional perf counters: EU_RDARB_PERF_EN.
module eu_cache_rd_arbiter
  import pkg_dtypes::*;
#(
  parameter int NUM_REQ   = EU_RDARB_NUM_REQ_DEFAULT,
  parameter int MAX_RETRY = EU_RDARB_MAX_RETRY_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic               [NUM_REQ-1:0]  req_valid_i,
  input  type_exec_unit_addr [NUM_REQ-1:0]  req_addr_i,
  output logic               [NUM_REQ-1:0]  rsp_valid_o,
  output logic                              rsp_fail_o,
  output type_exec_unit_data                rsp_data_o,
  output type_exec_unit_addr                icon_raddr_o,
  output logic                              icon_rvalid_o,
  input  logic                              icon_rsuccess_i,
  input  type_exec_unit_data                icon_rdata_i,
  output logic                              busy_o
`ifdef EU_RDARB_PERF_EN
  ,
  output logic               [31:0]         perf_fail_cnt_o,
  output logic               [31:0]         perf_grant_cnt_o
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] RETRY_LIMIT = CW'(MAX_RETRY);

  type_eu_rdarb_state state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant;
  logic [PW-1:0]      grant_next;
  logic [CW-1:0]      retry_cnt;
  logic [CW-1:0]      retry_next;
  logic [CW-1:0]      bo_cnt;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               pick_found;
  logic [PW-1:0]      pick_idx;

  // The requester being answered this cycle is masked out of the overlapping arbitration.
  eu_rr_pick #(
    .N  (NUM_REQ),
    .IW (PW)
  ) u_pick (
    .req   (req_valid_i),
    .mask  (rsp_valid_o),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign retry_next    = retry_cnt + CW'(1);
  assign grant_next    = PW'(eu_wrap_inc(int'(grant), NUM_REQ));
  assign grant_onehot  = NUM_REQ'(1) << grant;
  assign icon_rvalid_o = (state == ISSUE);
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      retry_cnt    <= '0;
      bo_cnt       <= '0;
      icon_raddr_o <= '0;
      rsp_valid_o  <= '0;
      rsp_fail_o   <= 1'b0;
      rsp_data_o   <= '0;
    end else begin
      rsp_valid_o <= '0;
      rsp_fail_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant        <= pick_idx;
            icon_raddr_o <= req_addr_i[pick_idx];
            retry_cnt    <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (icon_rsuccess_i) begin
            rsp_data_o  <= icon_rdata_i;
            rsp_valid_o <= grant_onehot;
            rr_ptr      <= grant_next;
            state       <= IDLE;
          end else begin
            retry_cnt <= retry_next;
            if (retry_next == RETRY_LIMIT) begin
              rsp_valid_o <= grant_onehot;
              rsp_fail_o  <= 1'b1;
              rr_ptr      <= grant_next;
              state       <= IDLE;
            end else begin
              // Backoff after the n-th failure lasts n cycles.
              bo_cnt <= retry_next;
              state  <= BACKOFF;
            end
          end
        end
        BACKOFF: begin
          bo_cnt <= bo_cnt - CW'(1);
          if (bo_cnt == CW'(1)) state <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EU_RDARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fail_cnt_o  <= '0;
      perf_grant_cnt_o <= '0;
    end else begin
      if (state == ISSUE && !icon_rsuccess_i && perf_fail_cnt_o != '1)
        perf_fail_cnt_o <= perf_fail_cnt_o + 32'd1;
      if (state == IDLE && pick_found && perf_grant_cnt_o != '1)
        perf_grant_cnt_o <= perf_grant_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eu_cache_rd_arbiter.sv
// Self-checking bench for eu_cache_rd_arbiter: scripted vector table, hand
// sequences for early drop and async reset, then randomized traffic vs a model.
module tb_eu_cache_rd_arbiter;
  import pkg_dtypes::*;

  localparam int N  = 4;
  localparam int MR = 3;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic               [N-1:0]  req_valid;
  type_exec_unit_addr [N-1:0]  req_addr;
  logic               [N-1:0]  rsp_valid;
  logic                        rsp_fail;
  type_exec_unit_data          rsp_data;
  type_exec_unit_addr          icon_raddr;
  logic                        icon_rvalid;
  logic                        icon_rsuccess;
  type_exec_unit_data          icon_rdata;
  logic                        busy;
`ifdef EU_RDARB_PERF_EN
  logic [31:0] perf_fail_cnt;
  logic [31:0] perf_grant_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  eu_cache_rd_arbiter #(
    .NUM_REQ   (N),
    .MAX_RETRY (MR)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .rsp_valid_o     (rsp_valid),
    .rsp_fail_o      (rsp_fail),
    .rsp_data_o      (rsp_data),
    .icon_raddr_o    (icon_raddr),
    .icon_rvalid_o   (icon_rvalid),
    .icon_rsuccess_i (icon_rsuccess),
    .icon_rdata_i    (icon_rdata),
    .busy_o          (busy)
`ifdef EU_RDARB_PERF_EN
    ,
    .perf_fail_cnt_o  (perf_fail_cnt),
    .perf_grant_cnt_o (perf_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] rv;
    logic         ok;
    logic         e_rv;
    logic [15:0]  e_ad;
    logic [N-1:0] e_rsp;
    logic         e_fail;
    logic         e_busy;
    logic [31:0]  e_data;
    logic         chk_data;
  } vec_t;

  vec_t tbl[39];

  function automatic vec_t mk(input logic [N-1:0] rv, input logic ok, input logic e_rv,
                              input logic [15:0] e_ad, input logic [N-1:0] e_rsp,
                              input logic e_fail, input logic e_busy, input logic [31:0] e_data);
    vec_t v;
    v.rv = rv; v.ok = ok; v.e_rv = e_rv; v.e_ad = e_ad; v.e_rsp = e_rsp;
    v.e_fail = e_fail; v.e_busy = e_busy; v.e_data = e_data;
    v.chk_data = (e_rsp != '0) && !e_fail;
    return v;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] rv, input logic ok, input logic [31:0] rd);
    req_valid     = rv;
    icon_rsuccess = ok;
    icon_rdata    = rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int idx, input logic e_rv, input logic [15:0] e_ad,
                          input logic [N-1:0] e_rsp, input logic e_fail, input logic e_busy,
                          input logic [31:0] e_data, input logic chk_data);
    checkOutput($sformatf("%s[%0d] rvalid", tag, idx), 32'(icon_rvalid), 32'(e_rv));
    checkOutput($sformatf("%s[%0d] raddr", tag, idx), 32'(icon_raddr), 32'(e_ad));
    checkOutput($sformatf("%s[%0d] busy", tag, idx), 32'(busy), 32'(e_busy));
    checkOutput($sformatf("%s[%0d] rsp_valid", tag, idx), 32'(rsp_valid), 32'(e_rsp));
    if (e_rsp != '0)
      checkOutput($sformatf("%s[%0d] rsp_fail", tag, idx), 32'(rsp_fail), 32'(e_fail));
    if (chk_data)
      checkOutput($sformatf("%s[%0d] rsp_data", tag, idx), rsp_data, e_data);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " rvalid"}, 32'(icon_rvalid), 32'd0);
    checkOutput({tag, " raddr"}, 32'(icon_raddr), 32'd0);
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, " rsp_fail"}, 32'(rsp_fail), 32'd0);
    checkOutput({tag, " rsp_data"}, rsp_data, 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Reference model state for the random phase (transaction schedule based).
  int           tfree, rr_m, g_m, grant_t, resp_t, succ_t;
  logic         fail_m;
  logic [31:0]  data_m;
  logic [15:0]  exp_addr;
  int           issue_q[$];
  logic         e_rv, e_busy, ok_r;
  logic [N-1:0] e_rsp, rv_r, mask_m;
  logic [31:0]  rd_r;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < N; k++) req_addr[k] = 16'h13 + 16'(k);
    applyStimulus('0, 1'b0, 32'h0);

    // rows: rv, ok, exp rvalid, exp raddr, exp rsp_valid, exp fail, exp busy, exp data
    tbl[0]  = mk(4'b1011, 0, 0, 16'h00, 4'b0000, 0, 0, 32'h0);
    tbl[1]  = mk(4'b1011, 1, 1, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[2]  = mk(4'b1010, 0, 0, 16'h13, 4'b0001, 0, 0, 32'hD000_0001);
    tbl[3]  = mk(4'b1011, 1, 1, 16'h14, 4'b0000, 0, 1, 32'h0);
    tbl[4]  = mk(4'b1001, 0, 0, 16'h14, 4'b0010, 0, 0, 32'hD000_0003);
    tbl[5]  = mk(4'b1011, 1, 1, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[6]  = mk(4'b0011, 0, 0, 16'h16, 4'b1000, 0, 0, 32'hD000_0005);
    tbl[7]  = mk(4'b1011, 1, 1, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[8]  = mk(4'b1010, 0, 0, 16'h13, 4'b0001, 0, 0, 32'hD000_0007);
    tbl[9]  = mk(4'b1011, 1, 1, 16'h14, 4'b0000, 0, 1, 32'h0);
    tbl[10] = mk(4'b1001, 0, 0, 16'h14, 4'b0010, 0, 0, 32'hD000_0009);
    tbl[11] = mk(4'b1011, 1, 1, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[12] = mk(4'b0000, 0, 0, 16'h16, 4'b1000, 0, 0, 32'hD000_000B);
    tbl[13] = mk(4'b0000, 0, 0, 16'h16, 4'b0000, 0, 0, 32'h0);
    tbl[14] = mk(4'b0100, 0, 0, 16'h16, 4'b0000, 0, 0, 32'h0);
    tbl[15] = mk(4'b0100, 1, 1, 16'h15, 4'b0000, 0, 1, 32'h0);
    tbl[16] = mk(4'b0000, 0, 0, 16'h15, 4'b0100, 0, 0, 32'hD000_000F);
    tbl[17] = mk(4'b0001, 0, 0, 16'h15, 4'b0000, 0, 0, 32'h0);
    tbl[18] = mk(4'b0001, 0, 1, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[19] = mk(4'b0001, 0, 0, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[20] = mk(4'b0001, 0, 1, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[21] = mk(4'b0001, 0, 0, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[22] = mk(4'b0001, 0, 0, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[23] = mk(4'b0001, 1, 1, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[24] = mk(4'b0000, 0, 0, 16'h13, 4'b0001, 0, 0, 32'hD000_0017);
    tbl[25] = mk(4'b1000, 0, 0, 16'h13, 4'b0000, 0, 0, 32'h0);
    tbl[26] = mk(4'b1000, 0, 1, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[27] = mk(4'b1000, 0, 0, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[28] = mk(4'b1000, 0, 1, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[29] = mk(4'b1000, 0, 0, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[30] = mk(4'b1000, 0, 0, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[31] = mk(4'b1000, 0, 1, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[32] = mk(4'b1000, 0, 0, 16'h16, 4'b1000, 1, 0, 32'h0);
    tbl[33] = mk(4'b1001, 0, 0, 16'h16, 4'b0000, 0, 0, 32'h0);
    tbl[34] = mk(4'b1001, 1, 1, 16'h13, 4'b0000, 0, 1, 32'h0);
    tbl[35] = mk(4'b1000, 0, 0, 16'h13, 4'b0001, 0, 0, 32'hD000_0022);
    tbl[36] = mk(4'b0000, 1, 1, 16'h16, 4'b0000, 0, 1, 32'h0);
    tbl[37] = mk(4'b0000, 0, 0, 16'h16, 4'b1000, 0, 0, 32'hD000_0024);
    tbl[38] = mk(4'b0000, 0, 0, 16'h16, 4'b0000, 0, 0, 32'h0);

    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 39; i++) begin
      if (i > 0) @(negedge clk);
      checkAll("tbl", i, tbl[i].e_rv, tbl[i].e_ad, tbl[i].e_rsp, tbl[i].e_fail,
               tbl[i].e_busy, tbl[i].e_data, tbl[i].chk_data);
      applyStimulus(tbl[i].rv, tbl[i].ok, 32'hD000_0000 + 32'(i));
    end

    // Early drop: requester 1 withdraws right after grant, still gets its answer.
    @(negedge clk);
    checkAll("drop", 0, 0, 16'h16, 4'b0000, 0, 0, 32'h0, 0);
    applyStimulus(4'b0010, 1'b0, 32'h0);
    @(negedge clk);
    checkAll("drop", 1, 1, 16'h14, 4'b0000, 0, 1, 32'h0, 0);
    applyStimulus(4'b0000, 1'b1, 32'hCAFE_0001);
    @(negedge clk);
    checkAll("drop", 2, 0, 16'h14, 4'b0010, 0, 0, 32'hCAFE_0001, 1);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    checkAll("drop", 3, 0, 16'h14, 4'b0000, 0, 0, 32'h0, 0);
    applyStimulus(4'b1000, 1'b0, 32'h0);

    // Reset asserted while backing off aborts the read silently.
    @(negedge clk);
    checkAll("rstseq", 0, 1, 16'h16, 4'b0000, 0, 1, 32'h0, 0);
    applyStimulus(4'b1000, 1'b0, 32'h0);
    @(negedge clk);
    checkAll("rstseq", 1, 0, 16'h16, 4'b0000, 0, 1, 32'h0, 0);
    reset_n = 1'b0;
    #1;
    checkResetState("rst_async");
    @(negedge clk);
    checkResetState("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    checkAll("rstseq", 2, 0, 16'h00, 4'b0000, 0, 0, 32'h0, 0);
    applyStimulus(4'b1001, 1'b0, 32'h0);
    @(negedge clk);
    checkAll("rstseq", 3, 1, 16'h13, 4'b0000, 0, 1, 32'h0, 0);
    applyStimulus(4'b1001, 1'b1, 32'hBEEF_0002);
    @(negedge clk);
    checkAll("rstseq", 4, 0, 16'h13, 4'b0001, 0, 0, 32'hBEEF_0002, 1);
    applyStimulus(4'b0000, 1'b0, 32'h0);

    // Randomized traffic against a schedule-level model.
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tfree = 0; rr_m = 0; g_m = 0; grant_t = -10; resp_t = -1; succ_t = -1;
    fail_m = 1'b0; data_m = '0; exp_addr = '0;
    issue_q.delete();

    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      e_rv = (issue_q.size() > 0) && (issue_q[0] == c);
      if (e_rv) void'(issue_q.pop_front());
      e_busy = (c > grant_t) && (c < resp_t);
      e_rsp  = (c == resp_t) ? (N'(1) << g_m) : '0;
      checkAll("rnd", c, e_rv, exp_addr, e_rsp, fail_m, e_busy, data_m, (c == resp_t) && !fail_m);

      for (int k = 0; k < N; k++) begin
        rv_r[k]     = ($urandom_range(0, 99) < 45);
        req_addr[k] = 16'($urandom);
      end
      rd_r = $urandom;
      ok_r = (c == succ_t) ? 1'b1 : (e_rv ? 1'b0 : 1'($urandom_range(0, 1)));
      applyStimulus(rv_r, ok_r, rd_r);
      if (c == succ_t) data_m = rd_r;

      if (c >= tfree) begin
        mask_m = (c == resp_t) ? (N'(1) << g_m) : '0;
        for (int i = 0; i < N; i++) begin
          int k;
          k = (rr_m + i) % N;
          if (c >= tfree && rv_r[k] && !mask_m[k]) begin
            int rej, t;
            g_m      = k;
            grant_t  = c;
            exp_addr = req_addr[k];
            rr_m     = (k + 1) % N;
            rej      = $urandom_range(0, MR);
            t        = c + 1;
            for (int a = 1; a <= MR; a++) begin
              issue_q.push_back(t);
              if (a == rej + 1) begin
                succ_t = t; resp_t = t + 1; fail_m = 1'b0;
                break;
              end
              if (a == MR) begin
                succ_t = -1; resp_t = t + 1; fail_m = 1'b1;
                break;
              end
              t = t + a + 1;
            end
            tfree = resp_t;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
